// File: rtl/note_recorder_pkg.sv
// Shared types and entry layout for the keypad note recorder.
// An entry is {rest, code, dur}, with dur in the DUR_W least-significant bits.
package note_recorder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } state_t;

  localparam int CODE_W = 4;

  // Value of the rest flag for a silent segment.
  localparam logic REST = 1'b1;

  function automatic int code_lsb(input int dur_w);
    return dur_w;
  endfunction

  function automatic int rest_bit(input int dur_w);
    return dur_w + CODE_W;
  endfunction

  function automatic int entry_w(input int dur_w);
    return dur_w + CODE_W + 1;
  endfunction

endpackage

// File: rtl/note_buffer.sv
// Single-port synchronous RAM holding recorded segments.
// Reads are registered, so data appears one cycle after the address.
module note_buffer
  import note_recorder_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = entry_w(12)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; the entry count alone marks which words are valid.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/note_recorder.sv
// Keypad note recorder/player: live passthrough, timed segment recording, replay.
// Assumes TICK_DIV >= 2 so the next entry can be prefetched before the current one expires.
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int DUR_W    = 12,
  parameter int TICK_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CODE_W-1:0]      key_code,
  input  logic                   key_down,
  input  logic                   rec_btn,
  input  logic                   play_btn,
  output logic [CODE_W-1:0]      note,
  output logic                   note_en,
  output logic                   recording,
  output logic                   playing,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int EW       = entry_w(DUR_W);
  localparam int CODE_LSB = code_lsb(DUR_W);
  localparam int REST_BIT = rest_bit(DUR_W);
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_MAX    = '1;
  localparam logic [CW-1:0]    LAST_SLOT  = CW'(DEPTH - 1);

  state_t state, state_nx;

  logic              rec_q, play_q, rec_rise, play_rise;
  logic [PW-1:0]     presc;
  logic              tick;
  logic              seg_open, seg_key, seg_changed, seg_sat;
  logic [CODE_W-1:0] seg_code, live_code;
  logic [DUR_W-1:0]  seg_ticks, seg_dur;
  logic              commit, seg_start, play_start, entry_load, play_pending;
  logic [CW-1:0]     play_idx;
  logic [DUR_W-1:0]  ticks_left;
  logic              we;
  logic [AW-1:0]     addr;
  logic [EW-1:0]     wdata, rdata;
  logic [DUR_W-1:0]  rd_dur;
  logic [CODE_W-1:0] rd_code;
  logic              rd_rest;

  assign rec_rise  = rec_btn & ~rec_q;
  assign play_rise = play_btn & ~play_q;
  assign tick      = (presc == PRESC_LAST);

  // Rests carry no code, so a code change while no key is held is not a new segment.
  assign live_code   = key_down ? key_code : '0;
  assign seg_changed = (key_down != seg_key) || (live_code != seg_code);
  assign seg_sat     = tick && (seg_ticks == DUR_MAX - 1'b1);
  assign seg_dur     = (seg_ticks == '0 && !tick) ? DUR_W'(1) : seg_ticks + DUR_W'(tick);

  assign rd_dur  = rdata[DUR_W-1:0];
  assign rd_code = rdata[CODE_LSB +: CODE_W];
  assign rd_rest = rdata[REST_BIT];

  assign we    = commit;
  assign wdata = {(seg_key ? ~REST : REST), seg_code, seg_dur};
  assign addr  = (state == REC) ? count[AW-1:0] : play_idx[AW-1:0];

  note_buffer #(
    .DEPTH(DEPTH),
    .WIDTH(EW)
  ) u_buf (
    .clk  (clk),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx   = state;
    commit     = 1'b0;
    seg_start  = 1'b0;
    play_start = 1'b0;
    entry_load = 1'b0;
    case (state)
      IDLE: begin
        if (rec_rise) begin
          state_nx = REC;
        end else if (play_rise && count != '0) begin
          state_nx   = PLAY;
          play_start = 1'b1;
        end
      end
      REC: begin
        if (rec_rise) begin
          commit   = seg_open && seg_key;
          state_nx = IDLE;
        end else if (!seg_open) begin
          seg_start = key_down;
        end else if (seg_changed || seg_sat) begin
          commit    = 1'b1;
          seg_start = 1'b1;
        end
        if (commit && count == LAST_SLOT) state_nx = IDLE;
      end
      PLAY: begin
        if (play_rise) begin
          state_nx = IDLE;
        end else if (play_pending) begin
          entry_load = 1'b1;
        end else if (tick && ticks_left == DUR_W'(1)) begin
          if (play_idx == count) state_nx = IDLE;
          else                   entry_load = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_q        <= 1'b0;
      play_q       <= 1'b0;
      presc        <= '0;
      count        <= '0;
      seg_open     <= 1'b0;
      seg_key      <= 1'b0;
      seg_code     <= '0;
      seg_ticks    <= '0;
      play_pending <= 1'b0;
      play_idx     <= '0;
      ticks_left   <= '0;
      note         <= '0;
      note_en      <= 1'b0;
      recording    <= 1'b0;
      playing      <= 1'b0;
    end else begin
      rec_q     <= rec_btn;
      play_q    <= play_btn;
      recording <= (state_nx == REC);
      playing   <= (state_nx == PLAY);

      if (seg_start || entry_load || tick) presc <= '0;
      else                                 presc <= presc + 1'b1;

      if (state == IDLE && state_nx == REC) begin
        count    <= '0;
        seg_open <= 1'b0;
      end else if (commit) begin
        count <= count + 1'b1;
      end

      if (seg_start) begin
        seg_open  <= 1'b1;
        seg_key   <= key_down;
        seg_code  <= live_code;
        seg_ticks <= '0;
      end else if (tick && state == REC) begin
        seg_ticks <= seg_ticks + 1'b1;
      end

      // play_idx names the entry being prefetched; the first load comes from the start read.
      play_pending <= play_start;
      if (state_nx != PLAY)               play_idx <= '0;
      else if (play_start)                play_idx <= CW'(1);
      else if (entry_load && !play_pending) play_idx <= play_idx + 1'b1;

      if (entry_load)                 ticks_left <= rd_dur;
      else if (tick && state == PLAY) ticks_left <= ticks_left - 1'b1;

      if (state_nx != PLAY) begin
        note    <= key_code;
        note_en <= key_down;
      end else if (entry_load) begin
        note    <= rd_code;
        note_en <= (rd_rest != REST);
      end
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Scoreboard bench for note_recorder: recorded segments are modelled into expected
// entries, expanded into per-cycle playback expectations and popped as the DUT plays.
module tb_note_recorder;

  localparam int DEPTH    = 4;
  localparam int DUR_W    = 4;
  localparam int TICK_DIV = 4;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int DMAX     = (1 << DUR_W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    key_code = '0;
  logic          key_down = 1'b0;
  logic          rec_btn = 1'b0;
  logic          play_btn = 1'b0;
  logic [3:0]    note;
  logic          note_en;
  logic          recording;
  logic          playing;
  logic [CW-1:0] count;

  typedef struct { bit en; int code; int cycles; } seg_t;
  typedef struct { bit rest; int code; int dur; } ent_t;

  seg_t       seg_q[$];
  ent_t       ent_q[$];
  logic [5:0] cyc_q[$];
  logic [4:0] live_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  note_recorder #(
    .DEPTH(DEPTH),
    .DUR_W(DUR_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_code (key_code),
    .key_down (key_down),
    .rec_btn  (rec_btn),
    .play_btn (play_btn),
    .note     (note),
    .note_en  (note_en),
    .recording(recording),
    .playing  (playing),
    .count    (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rec();
    rec_btn = 1'b1;
    step();
    rec_btn = 1'b0;
  endtask

  task automatic add_seg(input bit en, input int code, input int cycles);
    seg_t s;
    s.en = en;
    s.code = code;
    s.cycles = cycles;
    seg_q.push_back(s);
  endtask

  // Expected buffer contents: leading and trailing rests dropped, long segments split at
  // DMAX ticks, durations floor(cycles/TICK_DIV) with a minimum of 1, capped at DEPTH.
  task automatic model_record();
    bit open;
    open = 1'b0;
    ent_q.delete();
    foreach (seg_q[i]) begin
      int c;
      c = seg_q[i].cycles;
      if (!seg_q[i].en && !open) continue;
      if (!seg_q[i].en && i == seg_q.size() - 1) continue;
      open = 1'b1;
      while (c > 0 && ent_q.size() < DEPTH) begin
        int   take;
        ent_t e;
        take   = (c >= DMAX * TICK_DIV) ? DMAX * TICK_DIV : c;
        e.rest = !seg_q[i].en;
        e.code = seg_q[i].en ? seg_q[i].code : 0;
        e.dur  = (take / TICK_DIV < 1) ? 1 : take / TICK_DIV;
        ent_q.push_back(e);
        c -= take;
      end
    end
  endtask

  task automatic record_run(input bit final_rec);
    pulse_rec();
    foreach (seg_q[i]) begin
      key_down = seg_q[i].en;
      key_code = 4'(seg_q[i].code);
      for (int k = 0; k < seg_q[i].cycles; k++) begin
        if (!seg_q[i].en) key_code = 4'($urandom);
        step();
      end
    end
    if (final_rec) pulse_rec();
    key_down = 1'b0;
    key_code = '0;
    step();
    step();
    model_record();
    check("rec_count", 32'(count), 32'(ent_q.size()));
    check("rec_done_idle", 32'(recording), 32'(0));
  endtask

  task automatic play_run();
    cyc_q.delete();
    foreach (ent_q[i])
      for (int k = 0; k < ent_q[i].dur * TICK_DIV; k++)
        cyc_q.push_back({1'b1, ~ent_q[i].rest, 4'(ent_q[i].code)});
    play_btn = 1'b1;
    step();
    play_btn = 1'b0;
    check("play_started", 32'(playing), 32'(1));
    step();
    while (cyc_q.size() > 0) begin
      logic [5:0] e;
      e = cyc_q.pop_front();
      check("play_on", 32'({playing, note_en}), 32'(e[5:4]));
      if (e[4]) check("play_note", 32'(note), 32'(e[3:0]));
      step();
    end
    check("play_end", 32'(playing), 32'(0));
    check("play_end_en", 32'(note_en), 32'(0));
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_note", 32'(note), 32'(0));
    check("rst_en", 32'(note_en), 32'(0));
    check("rst_flags", 32'({recording, playing}), 32'(0));
    check("rst_count", 32'(count), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Live passthrough with one cycle of latency.
    for (int i = 0; i < 4; i++) begin
      key_down = (i != 2);
      key_code = 4'(3 * i + 4);
      live_q.push_back({key_down, key_code});
      step();
      check("live", 32'({note_en, note}), 32'(live_q.pop_front()));
    end
    key_down = 1'b0;
    step();

    // Play with an empty buffer stays idle and keeps passthrough.
    play_btn = 1'b1;
    step();
    play_btn = 1'b0;
    check("empty_play", 32'(playing), 32'(0));
    key_down = 1'b1;
    key_code = 4'd6;
    step();
    check("empty_live", 32'({playing, note_en, note}), 32'({1'b0, 1'b1, 4'd6}));
    key_down = 1'b0;
    step();

    // Note, rest, note, trailing rest.
    seg_q.delete();
    add_seg(1, 5, 12);
    add_seg(0, 0, 8);
    add_seg(1, 9, 4);
    add_seg(0, 0, 3);
    record_run(1'b1);
    play_run();

    // Abort playback partway through the first entry.
    play_btn = 1'b1;
    step();
    play_btn = 1'b0;
    repeat (5) step();
    check("abort_mid", 32'(playing), 32'(1));
    play_btn = 1'b1;
    key_down = 1'b1;
    key_code = 4'd7;
    step();
    check("abort_idle", 32'({playing, note_en, note}), 32'({1'b0, 1'b1, 4'd7}));
    play_btn = 1'b0;
    key_down = 1'b0;
    step();

    // Long note ended by rec_btn: saturation split.
    seg_q.delete();
    add_seg(1, 3, 70);
    record_run(1'b1);
    play_run();

    // Leading rest, then five notes: buffer fills after four.
    seg_q.delete();
    add_seg(0, 0, 3);
    add_seg(1, 1, 4);
    add_seg(1, 2, 6);
    add_seg(1, 3, 5);
    add_seg(1, 4, 9);
    add_seg(1, 5, 4);
    record_run(1'b0);
    play_run();

    // Asynchronous reset in the middle of recording.
    pulse_rec();
    key_down = 1'b1;
    key_code = 4'd3;
    repeat (5) step();
    key_code = 4'd4;
    repeat (5) step();
    check("pre_rst_count", 32'(count), 32'(1));
    check("pre_rst_rec", 32'(recording), 32'(1));
    #3 rst = 1'b1;
    #1;
    check("arst_out", 32'({note_en, note}), 32'(0));
    check("arst_flags", 32'({recording, playing}), 32'(0));
    check("arst_count", 32'(count), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    key_down = 1'b0;
    step();
    play_btn = 1'b1;
    step();
    play_btn = 1'b0;
    check("post_rst_play", 32'(playing), 32'(0));
    step();
    check("post_rst_idle", 32'(playing), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/note_recorder.md
# note_recorder

Keypad note recorder and player sitting directly upstream of the frequency lookup and buzzer. In live mode it passes the scanner's key code and key-held flag straight through. In record mode it logs timed note and rest segments into an internal buffer. In play mode it replays the buffer with millisecond timing on the same `note`/`note_en` outputs that feed the lookup and buzzer.

## Interface
Parameters:
- `DEPTH`, 32: buffer entries (power of two).
- `DUR_W`, 12: duration field width, in ticks; maximum segment length is 2^DUR_W−1 ticks.
- `TICK_DIV`, 50000: clk cycles per tick (1 ms at 50 MHz).

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: asynchronous reset, active-high.
- `key_code` in 4: scanner key code, valid while `key_down`=1.
- `key_down` in 1: scanner key-held level, synchronous to clk.
- `rec_btn` in 1: record toggle, level; the block edge-detects it.
- `play_btn` in 1: play toggle, level; the block edge-detects it.
- `note` out 4: key code to the frequency lookup.
- `note_en` out 1: buzzer enable.
- `recording` out 1: FSM is in REC.
- `playing` out 1: FSM is in PLAY.
- `count` out $clog2(DEPTH)+1: number of stored entries.

## Operation
- Entry format: {rest, code[3:0], dur[DUR_W-1:0]}.
- FSM states:
  - IDLE: live passthrough.
  - REC: recording, live passthrough.
  - PLAY: playback.
- Rising edge of `rec_btn` or `play_btn` = 0→1 between consecutive clk samples.
- IDLE:
  - `rec_btn` rise: clear `count`, go to REC.
  - `play_btn` rise with `count`>0: go to PLAY at entry 0.
  - `play_btn` rise with `count`=0: stay in IDLE.
- REC, segment tracking:
  - A segment is a maximal run of constant {`key_down`, `key_code`}. `key_code` is ignored while `key_down`=0.
  - The segment ends when that pair changes, or when its tick count reaches 2^DUR_W−1. The entry is committed and a new segment starts on the same cycle.
  - Stored dur = ticks elapsed, minimum 1.
  - Rests before the first key press are not stored.
- REC, exit:
  - `rec_btn` rise: commit the open segment only if it is a note (trailing rests are dropped), then go to IDLE.
  - Commit that makes `count`=DEPTH: go to IDLE immediately.
  - `play_btn` is ignored in REC.
- PLAY:
  - Entry i drives `note`=code and `note_en`=~rest for exactly dur×TICK_DIV cycles, then i advances.
  - After entry `count`−1 expires, go to IDLE.
  - `play_btn` rise aborts to IDLE.
  - `rec_btn` is ignored.
  - `count` is preserved; replaying is allowed.
- IDLE and REC outputs: `note`=`key_code`, `note_en`=`key_down`, registered (one-cycle latency).
- Reset values: state IDLE, `count`=0, `note`=0, `note_en`=0, `recording`=0, `playing`=0, prescaler=0, edge-detect registers=0.
- Reset mid-operation returns to IDLE with the buffer logically empty. Buffer contents need no clearing.

## Timing
- Prescaler counts 0..TICK_DIV−1 and emits a tick on wrap.
- The prescaler restarts at 0 on the cycle a REC segment starts and on the cycle a PLAY entry starts, so durations are exact multiples of TICK_DIV.
- Button edge to state change: 1 cycle; `recording`/`playing` reflect the new state on the next edge.
- PLAY start: `note`/`note_en` show entry 0 two cycles after the `play_btn` rise (state change, then buffer read).
- PLAY entry transitions: the read is pipelined so consecutive entries follow with no gap cycle.
- Simultaneous events:
  - Segment change and duration saturation on the same cycle commit one entry.
  - Buffer-full and `rec_btn` rise on the same cycle commit one entry and go to IDLE.
  - `rec_btn` and `play_btn` rising together in IDLE: `rec_btn` wins.

## Structure
- Package `note_recorder_pkg`: state enum {IDLE, REC, PLAY}, entry field widths and offsets, `REST` flag constant.
- Sub-module `note_buffer`: single-port synchronous RAM, DEPTH × (5+DUR_W), one-cycle read latency.
- Top of this block holds the FSM, prescaler, segment tracker, edge detectors and output registers.

## Test plan
All scenarios use TICK_DIV=4, DUR_W=4, DEPTH=4.
- Record, key 5 held 12 cycles, rest 8 cycles, key 9 held 4 cycles, `rec_btn` → `count`=3, entries {0,5,3}, {1,x,2}, {0,9,1}. Then `play_btn` → `note_en` high 12 cycles with `note`=5, low 8 cycles, high 4 cycles with `note`=9, then `playing`=0.
- Record, key 3 held 70 cycles → saturation splits it into entries of dur 15 and dur 2 (17 ticks, plus remainder cycles counted as 1 tick minimum).
- Record five alternating notes → state returns to IDLE when `count`=4; the fifth segment is not stored.
- `play_btn` with `count`=0 → `playing` stays 0, live passthrough continues.
- `play_btn` rise mid-entry → IDLE next cycle, `note_en` follows `key_down`. Assert `rst` mid-REC → all outputs 0, `count`=0 asynchronously.
